// File: rtl/manch_pkg.sv
// Shared Manchester definitions: FSM states, wire symbols and default sync word.
// The decoder uses the same symbol constants, so both ends agree on "10" = 1.
package manch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SYNC,
    DATA,
    GAP
  } state_t;

  // Wire pattern per logical bit, first half in bit [1], second half in bit [0].
  localparam logic [1:0] SYM_ONE  = 2'b10;
  localparam logic [1:0] SYM_ZERO = 2'b01;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hD5;

  // Half-symbol for a logical bit: phase 0 selects the first half, phase 1 the second.
  function automatic logic half_symbol(input logic bit_val, input logic half_sel);
    logic [1:0] sym;
    sym = bit_val ? SYM_ONE : SYM_ZERO;
    return half_sel ? sym[0] : sym[1];
  endfunction

endpackage

// File: rtl/manch_sym_gen.sv
// Registered Manchester half-symbol generator driving the line output.
module manch_sym_gen
  import manch_pkg::*;
(
  input  logic clk2x,
  input  logic rst_n,
  input  logic en,
  input  logic bit_val,
  input  logic phase,
  output logic dout
);

  // Register the selected half-symbol; the line idles low whenever en is low.
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 1'b0;
    end else begin
      dout <= en ? half_symbol(bit_val, phase) : 1'b0;
    end
  end

endmodule

// File: rtl/manch_encoder.sv
// Frame-level Manchester transmitter: preamble, sync word, payload (MSB first), forced gap.
module manch_encoder
  import manch_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                PRE_BITS  = 8,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD),
  parameter int                GAP_HALF  = 4
) (
  input  logic              clk2x,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              tx_abort,
  output logic              dout,
  output logic              busy
);

  localparam int MAX_BITS = (PRE_BITS > SYNC_W) ?
                            ((PRE_BITS > DATA_W) ? PRE_BITS : DATA_W) :
                            ((SYNC_W > DATA_W) ? SYNC_W : DATA_W);
  localparam int BIT_W = $clog2(MAX_BITS + 1);
  localparam int GAP_W = $clog2(GAP_HALF + 1);

  state_t             state, state_nx;
  logic               phase, phase_nx;
  logic [BIT_W-1:0]   bit_cnt, bit_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_nx;
  logic [DATA_W-1:0]  data_sr, data_nx;
  logic [SYNC_W-1:0]  sync_sr, sync_nx;
  logic               tx_ready_q, ready_nx;
  logic               sym_en, sym_bit, last_bit;

  // State, counters and shift registers; everything clears on reset so no partial word survives.
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data_sr    <= '0;
      sync_sr    <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      bit_cnt    <= bit_nx;
      gap_cnt    <= gap_nx;
      data_sr    <= data_nx;
      sync_sr    <= sync_nx;
      tx_ready_q <= ready_nx;
    end
  end

  // Next-state logic: walk PRE/SYNC/DATA one half-bit per cycle, abort jumps straight to GAP.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    bit_nx   = bit_cnt;
    gap_nx   = gap_cnt;
    data_nx  = data_sr;
    sync_nx  = sync_sr;
    sym_en   = 1'b0;
    sym_bit  = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_nx = PRE;
          data_nx  = tx_data;
          sync_nx  = SYNC_WORD;
          phase_nx = 1'b0;
          bit_nx   = '0;
          gap_nx   = '0;
        end
      end
      PRE, SYNC, DATA: begin
        if (tx_abort) begin
          state_nx = GAP;
          phase_nx = 1'b0;
          bit_nx   = '0;
          gap_nx   = '0;
          data_nx  = '0;
        end else begin
          sym_en   = 1'b1;
          phase_nx = ~phase;
          case (state)
            PRE: begin
              sym_bit  = 1'b1;
              last_bit = (bit_cnt == BIT_W'(PRE_BITS - 1));
            end
            SYNC: begin
              sym_bit  = sync_sr[SYNC_W-1];
              last_bit = (bit_cnt == BIT_W'(SYNC_W - 1));
            end
            default: begin
              sym_bit  = data_sr[DATA_W-1];
              last_bit = (bit_cnt == BIT_W'(DATA_W - 1));
            end
          endcase
          if (phase) begin
            if (state == SYNC) sync_nx = {sync_sr[SYNC_W-2:0], 1'b0};
            if (state == DATA) data_nx = {data_sr[DATA_W-2:0], 1'b0};
            if (last_bit) begin
              bit_nx = '0;
              case (state)
                PRE:     state_nx = SYNC;
                SYNC:    state_nx = DATA;
                default: state_nx = GAP;
              endcase
            end else begin
              bit_nx = bit_cnt + BIT_W'(1);
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_HALF - 1)) begin
          state_nx = IDLE;
          gap_nx   = '0;
        end else begin
          gap_nx = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx == IDLE);
  end

  assign tx_ready = tx_ready_q;
  assign busy     = (state != IDLE);

  manch_sym_gen u_sym_gen (
    .clk2x   (clk2x),
    .rst_n   (rst_n),
    .en      (sym_en),
    .bit_val (sym_bit),
    .phase   (phase),
    .dout    (dout)
  );

endmodule

// File: tb/tb_manch_encoder.sv
// Self-checking bench for manch_encoder: frame contents, timing, abort, reset, handshake rules.
module tb_manch_encoder;

  localparam int DATA_W       = 8;
  localparam int PRE_BITS     = 8;
  localparam int SYNC_W       = 8;
  localparam int GAP_HALF     = 4;
  localparam int FRAME_HALVES = 2 * (PRE_BITS + SYNC_W + DATA_W);
  localparam int FULL_END     = FRAME_HALVES + GAP_HALF;
  localparam int PERIOD       = 10;

  logic              clk2x    = 1'b0;
  logic              rst_n    = 1'b0;
  logic              tx_valid = 1'b0;
  logic              tx_abort = 1'b0;
  logic [DATA_W-1:0] tx_data  = '0;
  logic              tx_ready;
  logic              dout;
  logic              busy;

  int  checks   = 0;
  int  failures = 0;
  logic exp_dout [0:FULL_END];
  logic cap      [0:FULL_END];
  int  exp_end;
  time hs_time;

  always #(PERIOD/2) clk2x = ~clk2x;

  manch_encoder dut (
    .clk2x    (clk2x),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_abort (tx_abort),
    .dout     (dout),
    .busy     (busy)
  );

  // Expected line trace indexed by cycles after the handshake edge (index 0 = before first symbol).
  task automatic build_expected(input logic [DATA_W-1:0] d, input int abort_edge);
    bit          bits[$];
    logic [7:0]  sync_word;
    sync_word = 8'hD5;
    bits = {};
    for (int i = 0; i < PRE_BITS; i++) bits.push_back(1'b1);
    for (int i = SYNC_W - 1; i >= 0; i--) bits.push_back(sync_word[i]);
    for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(d[i]);
    for (int k = 0; k <= FULL_END; k++) exp_dout[k] = 1'b0;
    foreach (bits[i]) begin
      exp_dout[1 + 2*i] = bits[i];
      exp_dout[2 + 2*i] = ~bits[i];
    end
    exp_end = FULL_END;
    if (abort_edge >= 1 && abort_edge <= FRAME_HALVES) begin
      for (int k = abort_edge; k <= FULL_END; k++) exp_dout[k] = 1'b0;
      exp_end = abort_edge + GAP_HALF;
    end
  endtask

  // One frame: handshake, then per-cycle checks; mode 0 drops valid, 1 holds it, 2 toggles valid/data.
  task automatic run_frame(input logic [DATA_W-1:0] d, input int mode, input int abort_k,
                           input string name);
    int waited;
    int a;
    int run;
    int max_run;
    int errs;
    logic [DATA_W-1:0] dec;
    logic [1:0] pair;
    waited   = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk2x);
      waited++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_handshake: tx_ready=%b required 1 within 200 cycles", name, tx_ready);
      tx_valid = 1'b0;
      return;
    end
    a = (abort_k >= 0) ? abort_k + 1 : -1;
    build_expected(d, a);
    @(posedge clk2x);
    hs_time = $time;
    for (int k = 0; k <= exp_end; k++) begin
      @(negedge clk2x);
      cap[k] = dout;
      checks++;
      if (dout !== exp_dout[k]) begin
        failures++;
        $display("[TB] FAIL %s_dout cycle %0d: got %b required %b", name, k, dout, exp_dout[k]);
      end
      checks++;
      if (busy !== (k < exp_end)) begin
        failures++;
        $display("[TB] FAIL %s_busy cycle %0d: got %b required %b", name, k, busy, (k < exp_end));
      end
      checks++;
      if (tx_ready !== (k == exp_end)) begin
        failures++;
        $display("[TB] FAIL %s_ready cycle %0d: got %b required %b", name, k, tx_ready,
                 (k == exp_end));
      end
      tx_abort = (k == abort_k);
      case (mode)
        0: tx_valid = 1'b0;
        1: ;
        default: begin
          tx_data = DATA_W'($urandom);
          if (k < exp_end - 1) tx_valid = 1'($urandom_range(0, 1));
          else tx_valid = 1'b0;
        end
      endcase
    end
    tx_abort = 1'b0;
    if (a < 1 || a > FRAME_HALVES) begin
      run = 1;
      max_run = 1;
      for (int k = 2; k <= FRAME_HALVES; k++) begin
        run = (cap[k] == cap[k-1]) ? run + 1 : 1;
        if (run > max_run) max_run = run;
      end
      checks++;
      if (max_run > 2) begin
        failures++;
        $display("[TB] FAIL %s_runlength: longest run %0d required at most 2", name, max_run);
      end
      errs = 0;
      dec  = '0;
      for (int i = 0; i < DATA_W; i++) begin
        pair = {cap[1 + 2*(PRE_BITS + SYNC_W + i)], cap[2 + 2*(PRE_BITS + SYNC_W + i)]};
        if (pair == 2'b10) dec[DATA_W-1-i] = 1'b1;
        else if (pair == 2'b01) dec[DATA_W-1-i] = 1'b0;
        else errs++;
      end
      checks++;
      if (dec !== d || errs != 0) begin
        failures++;
        $display("[TB] FAIL %s_decode: got %h (%0d bad symbols) required %h", name, dec, errs, d);
      end
    end
  endtask

  // Outputs low during reset; tx_ready rises on the first edge after release.
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({dout, tx_ready, busy} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: dout/ready/busy=%b required 000", {dout, tx_ready, busy});
    end
    repeat (2) @(negedge clk2x);
    rst_n = 1'b1;
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready_before_edge: got %b required 0", tx_ready);
    end
    @(negedge clk2x);
    checks++;
    if ({dout, tx_ready, busy} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL reset_release: dout/ready/busy=%b required 010", {dout, tx_ready, busy});
    end
  endtask

  task automatic test_basic();
    run_frame(8'hA5, 0, -1, "basic_a5");
    run_frame(8'h3C, 0, -1, "basic_3c");
  endtask

  // Valid held high: second handshake lands exactly one frame plus gap plus one cycle later.
  task automatic test_back_to_back();
    time t0;
    run_frame(8'h00, 1, -1, "b2b_00");
    t0 = hs_time;
    run_frame(8'hFF, 1, -1, "b2b_ff");
    tx_valid = 1'b0;
    checks++;
    if (hs_time - t0 !== time'(53 * PERIOD)) begin
      failures++;
      $display("[TB] FAIL b2b_spacing: got %0t required %0t", hs_time - t0, time'(53 * PERIOD));
    end
  endtask

  // Abort mid-frame, at the last data half, ignored in GAP, and losing to a handshake in IDLE.
  task automatic test_abort();
    run_frame(8'h5A, 0, 29, "abort_mid");
    tx_abort = 1'b1;
    run_frame(8'h81, 0, -1, "abort_idle_81");
    run_frame(8'h3E, 0, 47, "abort_last_half");
    run_frame(8'hC6, 0, 49, "abort_in_gap");
    run_frame(8'h96, 0, 0, "abort_first");
  endtask

  // Asynchronous reset in DATA: outputs fall without an edge and nothing resumes afterwards.
  task automatic test_reset_mid();
    int waited;
    waited   = 0;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk2x);
      waited++;
    end
    @(posedge clk2x);
    tx_valid = 1'b0;
    repeat (40) @(negedge clk2x);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, busy, tx_ready} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rstmid_async: dout/busy/ready=%b required 000", {dout, busy, tx_ready});
    end
    @(negedge clk2x);
    rst_n = 1'b1;
    @(negedge clk2x);
    checks++;
    if ({dout, busy, tx_ready} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rstmid_release: dout/busy/ready=%b required 001", {dout, busy, tx_ready});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk2x);
      checks++;
      if (dout !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rstmid_residual cycle %0d: dout=%b busy=%b required 0 0", k, dout, busy);
      end
    end
    run_frame(8'h81, 0, -1, "rstmid_recover");
  endtask

  // Valid and data thrash during the frame; payload must be the handshake value.
  task automatic test_toggle();
    run_frame(8'h6B, 2, -1, "toggle_6b");
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    int mode;
    int ak;
    for (int i = 0; i < 8; i++) begin
      d    = DATA_W'($urandom);
      mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      ak   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 50)) : -1;
      run_frame(d, mode, ak, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
